// File: rtl/mcdf_pkg.sv
// Shared constants and types for the MCDF arbiter slice.
package mcdf_pkg;
   localparam int CH_NUM = 3;    // slave channels, a2f_id is 2 bits
   localparam int DW     = 32;   // data word width
   localparam int LW     = 3;    // length code width, packet = len+1 words
   localparam int PW     = 2;    // priority width, lower value wins

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_st_e;

   typedef logic [LW-1:0] len_t;
   typedef logic [PW-1:0] prio_t;
endpackage

// File: rtl/mcdf_rr_prio_sel.sv
// Combinational channel picker: lowest priority value wins, ties go to the
// first matching channel found searching upward from the last grant.
module mcdf_rr_prio_sel
   import mcdf_pkg::*;
(
   input  logic  [CH_NUM-1:0] i_elig,
   input  prio_t [CH_NUM-1:0] i_prio,
   input  logic  [1:0]        i_rr_last,
   output logic  [1:0]        o_gnt_id,
   output logic               o_found
);
   prio_t             w_min;
   logic [CH_NUM-1:0] w_cand;

   // Best (numerically smallest) priority among eligible channels.
   always_comb begin
      w_min = '1;
      for (int c = 0; c < CH_NUM; c++)
         if (i_elig[c] && (i_prio[c] < w_min)) w_min = i_prio[c];
   end

   // Channels tied at the best priority.
   always_comb begin
      for (int c = 0; c < CH_NUM; c++)
         w_cand[c] = i_elig[c] && (i_prio[c] == w_min);
   end

   // Round-robin tie-break, starting one past the last granted channel.
   always_comb begin
      logic v_hit;
      int   v_idx;
      v_hit    = 1'b0;
      v_idx    = 0;
      o_gnt_id = 2'd0;
      for (int k = 1; k <= CH_NUM; k++) begin
         v_idx = (int'(i_rr_last) + k) % CH_NUM;
         if (!v_hit && w_cand[v_idx]) begin
            o_gnt_id = 2'(v_idx);
            v_hit    = 1'b1;
         end
      end
   end

   assign o_found = |i_elig;
endmodule

// File: rtl/mcdf_arbiter.sv
// Shares the formatter port among three slave channels: one packet per
// grant, val/ack word handshake, one bubble cycle between packets.
module mcdf_arbiter
   import mcdf_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH_NUM-1:0]    slv_en,
   input  logic [CH_NUM*PW-1:0] slv_prio,
   input  logic [CH_NUM*LW-1:0] slv_len_cfg,
   input  logic [CH_NUM-1:0]    ch_val,
   input  logic [CH_NUM*DW-1:0] ch_dat,
   output logic [CH_NUM-1:0]    ch_rd,
   output logic                 a2f_val,
   output logic [1:0]           a2f_id,
   output logic [DW-1:0]        a2f_dat,
   output len_t                 slv0_len,
   output len_t                 slv1_len,
   output len_t                 slv2_len,
   input  logic                 f2a_ack
);
   arb_st_e                       r_state;
   logic    [1:0]                 r_gnt;
   logic    [1:0]                 r_rr_last;
   len_t                          r_cnt;
   len_t                          r_cnt_max;
   logic                          r_val;
   len_t    [CH_NUM-1:0]          r_len;

   logic    [CH_NUM-1:0]          w_elig;
   prio_t   [CH_NUM-1:0]          w_prio;
   len_t    [CH_NUM-1:0]          w_len_cfg;
   logic    [CH_NUM-1:0][DW-1:0]  w_dat;
   logic    [1:0]                 w_gnt_id;
   logic                          w_found;
   len_t                          w_len_sel;

   // Enable is only looked at here, so dropping it mid-packet has no effect.
   assign w_elig    = ch_val & slv_en;
   assign w_prio    = slv_prio;
   assign w_len_cfg = slv_len_cfg;
   assign w_dat     = ch_dat;

   mcdf_rr_prio_sel u_sel (
      .i_elig    (w_elig),
      .i_prio    (w_prio),
      .i_rr_last (r_rr_last),
      .o_gnt_id  (w_gnt_id),
      .o_found   (w_found)
   );

   // Length code of the channel about to be granted.
   always_comb begin
      case (w_gnt_id)
         2'd1:    w_len_sel = w_len_cfg[1];
         2'd2:    w_len_sel = w_len_cfg[2];
         default: w_len_sel = w_len_cfg[0];
      endcase
   end

   // Data mux follows the registered grant.
   always_comb begin
      case (r_gnt)
         2'd1:    a2f_dat = w_dat[1];
         2'd2:    a2f_dat = w_dat[2];
         default: a2f_dat = w_dat[0];
      endcase
   end

   // Pop strobe fires in the ack cycle; reset suppresses any pop.
   always_comb begin
      ch_rd = '0;
      if (!rst && (r_state == BUSY) && f2a_ack)
         ch_rd = CH_NUM'(1) << r_gnt;
   end

   // Arbitrate in IDLE, count words in BUSY; count limit is latched at grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= 2'd0;
         r_rr_last <= 2'd2;
         r_cnt     <= '0;
         r_cnt_max <= '0;
         r_val     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt     <= w_gnt_id;
                  r_rr_last <= w_gnt_id;
                  r_cnt_max <= w_len_sel;
                  r_cnt     <= '0;
                  r_val     <= 1'b1;
                  r_state   <= BUSY;
               end
            end
            BUSY: begin
               if (f2a_ack) begin
                  if (r_cnt == r_cnt_max) begin
                     r_val   <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_val   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Registered copies of the configured lengths, updated every cycle.
   always_ff @(posedge clk) begin
      if (rst) r_len <= '0;
      else     r_len <= w_len_cfg;
   end

   assign a2f_val  = r_val;
   assign a2f_id   = r_gnt;
   assign slv0_len = r_len[0];
   assign slv1_len = r_len[1];
   assign slv2_len = r_len[2];
endmodule
